// File: rtl/pad_input_filter.sv
// rtl/pad_input_filter.sv - pad input synchronizer, debouncer, edge detector and glitch counter
module pad_input_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 16,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pad_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] threshold_i,
    input  logic                 clear_i,
    output logic                 filt_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic [7:0]           glitch_cnt_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_rise;
    logic                   r_fall;
    logic [7:0]             r_glitch;

    logic                   w_sync;
    logic                   w_filt_d;
    logic [CNT_WIDTH-1:0]   w_cnt_d;
    logic                   w_glitch_end;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // cnt counts mismatching samples already absorbed; >= tolerates threshold dropping mid-run
    always_comb begin
        w_filt_d     = r_filt;
        w_cnt_d      = '0;
        w_glitch_end = 1'b0;
        if (!en_i) begin
            w_filt_d = w_sync;
        end else if (w_sync == r_filt) begin
            w_glitch_end = (r_cnt != '0);
        end else if (r_cnt >= threshold_i) begin
            w_filt_d = w_sync;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= {SYNC_STAGES{RESET_VALUE}};
            r_filt   <= RESET_VALUE;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 8'd0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
            r_filt <= w_filt_d;
            r_cnt  <= w_cnt_d;
            r_rise <= w_filt_d & ~r_filt;
            r_fall <= ~w_filt_d & r_filt;
            if (clear_i) begin
                r_glitch <= 8'd0;
            end else if (w_glitch_end && (r_glitch != 8'hFF)) begin
                r_glitch <= r_glitch + 8'd1;
            end
        end
    end

    assign filt_o       = r_filt;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign glitch_cnt_o = r_glitch;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && en_i && $isunknown(pad_i)) begin
            $error("pad_input_filter: pad_i is X/Z while filter enabled");
        end
    end
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// tb/tb_pad_input_filter.sv - scoreboard bench for pad_input_filter
module tb_pad_input_filter;

    localparam int   S  = 2;
    localparam logic RV = 1'b0;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pad_i = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] threshold_i = 16'd0;
    logic        clear_i = 1'b0;
    logic        filt_o, rise_o, fall_o;
    logic [7:0]  glitch_cnt_o;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       filt;
        logic       rise;
        logic       fall;
        logic [7:0] gc;
    } exp_t;

    exp_t sb[$];
    logic hist[$];
    logic m_filt;
    int   m_run;
    int   m_gc;

    pad_input_filter #(.SYNC_STAGES(S), .CNT_WIDTH(16), .RESET_VALUE(RV)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .pad_i(pad_i), .en_i(en_i),
        .threshold_i(threshold_i), .clear_i(clear_i), .filt_o(filt_o),
        .rise_o(rise_o), .fall_o(fall_o), .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(RV);
        m_filt = RV;
        m_run  = 0;
        m_gc   = 0;
    endtask

    // The level seen by the filter is the pad as it was S edges ago; a level
    // change is accepted once it has been seen on more than T successive samples.
    task automatic model_edge();
        logic s;
        logic nf;
        exp_t e;
        s = hist.pop_front();
        hist.push_back(pad_i);
        nf = m_filt;
        if (!en_i) begin
            nf = s;
            m_run = 0;
        end else if (s == m_filt) begin
            if (m_run > 0 && m_gc < 255) m_gc++;
            m_run = 0;
        end else begin
            m_run++;
            if (m_run > int'(threshold_i)) begin
                nf = s;
                m_run = 0;
            end
        end
        if (clear_i) m_gc = 0;
        e.filt = nf;
        e.rise = (nf == 1'b1) && (m_filt == 1'b0);
        e.fall = (nf == 1'b0) && (m_filt == 1'b1);
        e.gc   = 8'(m_gc);
        m_filt = nf;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({filt_o, rise_o, fall_o, glitch_cnt_o} !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got filt=%b rise=%b fall=%b gc=%0d, expected filt=%b rise=%b fall=%b gc=%0d",
                         $time, filt_o, rise_o, fall_o, glitch_cnt_o, e.filt, e.rise, e.fall, e.gc);
            end
            total++;
            if (rise_o && fall_o) begin
                bad++;
                $display("FAIL both_pulses t=%0t: got rise=1 fall=1, expected at most one", $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one clock edge, leave time just past the next falling edge.
    task automatic step(input logic p, input logic e, input logic [15:0] t, input logic c);
        pad_i = p;
        en_i = e;
        threshold_i = t;
        clear_i = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic p, input logic e, input logic [15:0] t, input logic c, input int n);
        for (int i = 0; i < n; i++) step(p, e, t, c);
    endtask

    initial begin
        logic        rp;
        logic        re;
        logic [15:0] rt;
        int          run;

        model_reset();
        pad_i = 1'b1;
        #12;
        check("reset_filt", 32'(filt_o), 32'(RV));
        check("reset_pulses", 32'({rise_o, fall_o}), 32'd0);
        check("reset_gc", 32'(glitch_cnt_o), 32'd0);

        // bypass from reset with pad high
        @(negedge clk);
        #1;
        rst_ni = 1'b1;
        hold(1'b1, 1'b0, 16'd0, 1'b0, 2);
        check("bypass_no_early_flip", 32'({filt_o, rise_o}), 32'd0);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        check("bypass_edge3", 32'({filt_o, rise_o}), 32'd3);
        hold(1'b1, 1'b0, 16'd0, 1'b0, 2);

        // debounce pass at T=4
        hold(1'b0, 1'b1, 16'd4, 1'b0, 10);
        hold(1'b1, 1'b1, 16'd4, 1'b0, 6);
        check("debounce_edge6", 32'({filt_o, rise_o}), 32'd0);
        step(1'b1, 1'b1, 16'd4, 1'b0);
        check("debounce_edge7", 32'({filt_o, rise_o}), 32'd3);
        step(1'b1, 1'b1, 16'd4, 1'b0);
        check("debounce_single_pulse", 32'(rise_o), 32'd0);
        check("debounce_gc", 32'(glitch_cnt_o), 32'd0);

        // glitch reject and saturation
        hold(1'b0, 1'b1, 16'd4, 1'b0, 10);
        hold(1'b1, 1'b1, 16'd4, 1'b0, 3);
        hold(1'b0, 1'b1, 16'd4, 1'b0, 8);
        check("glitch_filt", 32'(filt_o), 32'd0);
        check("glitch_gc1", 32'(glitch_cnt_o), 32'd1);
        for (int g = 0; g < 300; g++) begin
            hold(1'b1, 1'b1, 16'd4, 1'b0, 3);
            hold(1'b0, 1'b1, 16'd4, 1'b0, 5);
        end
        check("glitch_saturate", 32'(glitch_cnt_o), 32'd255);

        // clear on the edge where the glitch ends
        hold(1'b1, 1'b1, 16'd4, 1'b0, 3);
        hold(1'b0, 1'b1, 16'd4, 1'b0, 2);
        step(1'b0, 1'b1, 16'd4, 1'b1);
        hold(1'b0, 1'b1, 16'd4, 1'b0, 4);
        check("clear_priority", 32'(glitch_cnt_o), 32'd0);

        // threshold lowered mid-count
        hold(1'b1, 1'b1, 16'd10, 1'b0, 8);
        check("thr_change_before", 32'(filt_o), 32'd0);
        step(1'b1, 1'b1, 16'd3, 1'b0);
        check("thr_change_flip", 32'({filt_o, rise_o}), 32'd3);

        // async reset mid-count
        hold(1'b0, 1'b1, 16'd8, 1'b0, 7);
        check("pre_reset_filt", 32'(filt_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        pad_i = 1'b1;
        #1;
        check("async_reset_outputs", 32'({filt_o, rise_o, fall_o, glitch_cnt_o}), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_ni = 1'b1;

        // randomized runs
        rp = 1'b1;
        re = 1'b1;
        rt = 16'd2;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                rp = ~rp;
                run = $urandom_range(1, 8);
            end
            run--;
            if ($urandom_range(0, 19) == 0) re = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) rt = 16'($urandom_range(0, 6));
            step(rp, re, rt, $urandom_range(0, 39) == 0);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_input_filter.md
# pad_input_filter

Synchronizes and debounces one asynchronous pad input and produces a clean level plus edge events for the core. It sits directly downstream of an input pad cell: its `pad_i` is driven by the pad cell's `pad_out_o`, and its outputs feed GPIO/peripheral logic in the `clk_i` domain. A programmable consecutive-sample threshold rejects glitches. A saturating counter records rejected glitches for software diagnostics.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count. Legal range is 2 or more.
- `CNT_WIDTH`, default 16: width of the debounce counter and of `threshold_i`.
- `RESET_VALUE`, default 1'b0: reset level of the synchronizer chain and of `filt_o`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Reset is asynchronous and active-low.
- `pad_i`, in, 1: raw pad level, asynchronous to `clk_i`.
- `en_i`, in, 1: filter enable. When 0, the filter is bypassed.
- `threshold_i`, in, `CNT_WIDTH`: number of extra consecutive mismatching samples required before `filt_o` flips.
- `clear_i`, in, 1: synchronous clear of `glitch_cnt_o`.
- `filt_o`, out, 1: filtered level, driven from a register.
- `rise_o`, out, 1: one-cycle pulse on a 0→1 change of `filt_o`.
- `fall_o`, out, 1: one-cycle pulse on a 1→0 change of `filt_o`.
- `glitch_cnt_o`, out, 8: count of rejected glitches. Saturates at 255.

## Operation

Synchronizer:
- `sync` is the output of an `SYNC_STAGES`-deep flop chain on `pad_i`.
- All stages reset to `RESET_VALUE`.

Debounce state: `filt_q` (drives `filt_o`) and `cnt_q` (`CNT_WIDTH` bits). Per clock edge:
- `en_i`=0: `filt_q`←`sync`; `cnt_q`←0.
- `en_i`=1, `sync`==`filt_q`: `cnt_q`←0. If `cnt_q`≠0 (a mismatch run ended without a flip), `glitch_cnt` increments by 1, saturating at 255.
- `en_i`=1, `sync`≠`filt_q`, `cnt_q`≥`threshold_i`: `filt_q`←`sync`; `cnt_q`←0. The `≥` covers `threshold_i` being lowered mid-count.
- `en_i`=1, `sync`≠`filt_q`, `cnt_q`<`threshold_i`: `cnt_q`←`cnt_q`+1. No wrap is possible, because `cnt_q` never exceeds the largest `threshold_i`.
- `threshold_i`=0 behaves identically to bypass.

Edge pulses:
- `rise_o` and `fall_o` are registered. They are high for exactly one cycle, in the same cycle `filt_o` first shows the new value.
- They are never both high.
- They are generated in bypass mode too.

Glitch counter:
- `clear_i`=1 has priority over a simultaneous increment: the result is 0.
- Holds at 255 once saturated.
- A mismatch run cut short by `en_i` falling does not count as a glitch.

Reset:
- Asserting `rst_ni` at any time, including mid-count, immediately forces: sync chain and `filt_o` to `RESET_VALUE`; `cnt_q`=0; `rise_o`=`fall_o`=0; `glitch_cnt_o`=0.
- No edge pulse is generated on reset assertion or release, even if `pad_i` differs from `RESET_VALUE`.
- After release, a differing pad level is filtered like any other change.

Simulation-only check (`ifndef SYNTHESIS`): `$error` if `pad_i` is X or Z while `rst_ni`=1 and `en_i`=1.

## Timing

- Let `pad_i` change before edge 1, and let S=`SYNC_STAGES` and T=`threshold_i` (held constant).
  - `sync` shows the change after edge S.
  - `filt_o` and the matching edge pulse appear after edge S+T+1.
- With bypass or T=0, latency is S+1 edges: 3 edges at the defaults.
- A pad pulse is rejected if it is seen at `sync` for T or fewer consecutive cycles. It passes if seen for T+1 or more cycles.
- `glitch_cnt_o` updates on the edge at which `sync` returns to `filt_q`.
- `threshold_i` and `en_i` are sampled every edge. No handshake is required.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- **Reset / bypass:** release reset with `pad_i`=1, `en_i`=0, `RESET_VALUE`=0 → `filt_o`=1 and a `rise_o` pulse after edge 3. No pulse occurs at reset release itself.
- **Debounce pass:** `en_i`=1, T=4, `pad_i` 0→1 held → `filt_o`=1 and `rise_o` for one cycle after edge 7. `glitch_cnt_o` stays 0.
- **Glitch reject:** T=4, `pad_i` high for 3 cycles then low → `filt_o` stays 0, no pulses, `glitch_cnt_o`=1. A further 300 such glitches → `glitch_cnt_o`=255.
- **Threshold change mid-count:** T=10; after `cnt_q` reaches 6, write T=3 → flip on the next edge.
- **Clear priority:** `clear_i`=1 in the same cycle a glitch ends → `glitch_cnt_o`=0.
- **Async reset mid-count:** `filt_o`=1, `cnt_q`=5, pulse `rst_ni` low between edges → all outputs return to reset values immediately, without waiting for a clock edge.
